// File: rtl/axil_mitm_rd_pipe.sv
// -----------------------------------------------------------------------------
// axil_mitm_rd_pipe
//
// AXI4-Lite read-channel man-in-the-middle. Sits between an upstream master
// (s_axil_*) and a downstream slave (m_axil_*), forwarding reads while it:
//   - registers the AR channel (one cycle of latency, one request in flight
//     in the register at a time),
//   - tracks accepted-but-unanswered reads and backpressures AR when the
//     count reaches MAX_OUTSTANDING,
//   - holds each read response for a programmable number of cycles,
//   - XORs the returned data with a programmable mask,
//   - optionally forces SLVERR on the next captured response.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   s_axil_ar*             upstream AR channel (this block is the slave)
//   s_axil_r*              upstream R channel
//   m_axil_ar*             downstream AR channel (this block is the master)
//   m_axil_r*              downstream R channel
//   cfg_delay              extra hold cycles applied to each response
//   cfg_rdata_xor          mask XORed into forwarded rdata
//   cfg_err_inject         one-cycle pulse arming a single SLVERR injection
//   sts_outstanding        current number of outstanding reads
//   sts_err_pending        an injection is armed and not yet applied
// -----------------------------------------------------------------------------
module axil_mitm_rd_pipe #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DELAY_WIDTH     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [ADDR_WIDTH-1:0]                  s_axil_araddr,
    input  logic [2:0]                             s_axil_arprot,
    input  logic                                   s_axil_arvalid,
    output logic                                   s_axil_arready,
    output logic [DATA_WIDTH-1:0]                  s_axil_rdata,
    output logic [1:0]                             s_axil_rresp,
    output logic                                   s_axil_rvalid,
    input  logic                                   s_axil_rready,

    output logic [ADDR_WIDTH-1:0]                  m_axil_araddr,
    output logic [2:0]                             m_axil_arprot,
    output logic                                   m_axil_arvalid,
    input  logic                                   m_axil_arready,
    input  logic [DATA_WIDTH-1:0]                  m_axil_rdata,
    input  logic [1:0]                             m_axil_rresp,
    input  logic                                   m_axil_rvalid,
    output logic                                   m_axil_rready,

    input  logic [DELAY_WIDTH-1:0]                 cfg_delay,
    input  logic [DATA_WIDTH-1:0]                  cfg_rdata_xor,
    input  logic                                   cfg_err_inject,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   sts_outstanding,
    output logic                                   sts_err_pending
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_OUT   = 2'd2
    } r_state_t;

    // Saturating up/down counter step: simultaneous inc and dec cancel, and
    // the count is clamped to [0, MAX_OUTSTANDING] (an unsolicited response
    // must not wrap the count below zero).
    function automatic logic [CNT_W-1:0] sat_count(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec && (cnt < CNT_W'(MAX_OUTSTANDING)))
            res = cnt + CNT_W'(1);
        else if (dec && !inc && (cnt != '0))
            res = cnt - CNT_W'(1);
        return res;
    endfunction

    // Response code override for the error-injection feature.
    function automatic logic [1:0] inject_resp(
        input logic [1:0] resp,
        input logic       force_err
    );
        return force_err ? RESP_SLVERR : resp;
    endfunction

    // Control state (reset)
    logic                   ar_vld_p0;
    logic [CNT_W-1:0]       outstanding;
    logic                   err_pending;
    logic [DELAY_WIDTH-1:0] delay_cnt;
    r_state_t               state;

    // Datapath registers (not reset; zero initial value for simulation)
    logic [ADDR_WIDTH-1:0]  araddr_p0 = '0;
    logic [2:0]             arprot_p0 = '0;
    logic [DATA_WIDTH-1:0]  rdata_p1  = '0;
    logic [1:0]             rresp_p1  = '0;

    // Next-state / strobes from the R state machine
    r_state_t               state_nxt;
    logic [DELAY_WIDTH-1:0] delay_nxt;
    logic                   err_nxt;
    logic                   capture;

    logic                   s_ar_hs;
    logic                   s_r_hs;

    // Readies and valids are forced low while rst is asserted so the outputs
    // are quiet from the very first reset cycle, before the registers have
    // been cleared by the synchronous reset edge.
    assign s_axil_arready  = !rst && !ar_vld_p0
                             && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign m_axil_arvalid  = !rst && ar_vld_p0;
    assign m_axil_araddr   = araddr_p0;
    assign m_axil_arprot   = arprot_p0;

    assign m_axil_rready   = !rst && (state == R_IDLE);
    assign s_axil_rvalid   = !rst && (state == R_OUT);
    assign s_axil_rdata    = rdata_p1;
    assign s_axil_rresp    = rresp_p1;

    assign sts_outstanding = outstanding;
    assign sts_err_pending = err_pending;

    assign s_ar_hs = s_axil_arvalid && s_axil_arready;
    assign s_r_hs  = s_axil_rvalid && s_axil_rready;

    // ---- Stage p0: AR register slice ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_vld_p0 <= 1'b0;
        end else if (s_ar_hs) begin
            ar_vld_p0 <= 1'b1;
        end else if (m_axil_arready) begin
            ar_vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_ar_hs) begin
            araddr_p0 <= s_axil_araddr;
            arprot_p0 <= s_axil_arprot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= sat_count(outstanding, s_ar_hs, s_r_hs);
        end
    end

    // ---- Stage p1: R capture / delay / present ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= R_IDLE;
            delay_cnt   <= '0;
            err_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            delay_cnt   <= delay_nxt;
            err_pending <= err_nxt;
        end
    end

    // cfg_delay and cfg_rdata_xor are only looked at on the capture cycle, so
    // reprogramming them never disturbs a response already in the buffer.
    always_ff @(posedge clk) begin
        if (capture) begin
            rdata_p1 <= m_axil_rdata ^ cfg_rdata_xor;
            rresp_p1 <= inject_resp(m_axil_rresp, err_pending || cfg_err_inject);
        end
    end

    always_comb begin
        state_nxt = state;
        delay_nxt = delay_cnt;
        capture   = 1'b0;

        case (state)
            R_IDLE: begin
                if (m_axil_rvalid) begin
                    capture = 1'b1;
                    if (cfg_delay != '0) begin
                        state_nxt = R_DELAY;
                        delay_nxt = cfg_delay;
                    end else begin
                        state_nxt = R_OUT;
                    end
                end
            end
            R_DELAY: begin
                // Count reaches 1 on the last hold cycle; R_OUT follows, so
                // the response is held exactly cfg_delay cycles.
                delay_nxt = delay_cnt - DELAY_WIDTH'(1);
                if (delay_cnt <= DELAY_WIDTH'(1)) begin
                    state_nxt = R_OUT;
                    delay_nxt = '0;
                end
            end
            R_OUT: begin
                if (s_axil_rready) begin
                    state_nxt = R_IDLE;
                end
            end
            default: begin
                state_nxt = R_IDLE;
                delay_nxt = '0;
            end
        endcase

        // A pulse that lands on a capture is consumed by that capture; extra
        // pulses while already armed are absorbed.
        err_nxt = err_pending || cfg_err_inject;
        if (capture) begin
            err_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_mitm_rd_pipe.sv
module tb_axil_mitm_rd_pipe;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MO  = 4;
    localparam int DLW = 8;
    localparam int CW  = $clog2(MO + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  s_axil_araddr;
    logic [2:0]     s_axil_arprot;
    logic           s_axil_arvalid;
    logic           s_axil_arready;
    logic [DW-1:0]  s_axil_rdata;
    logic [1:0]     s_axil_rresp;
    logic           s_axil_rvalid;
    logic           s_axil_rready;
    logic [AW-1:0]  m_axil_araddr;
    logic [2:0]     m_axil_arprot;
    logic           m_axil_arvalid;
    logic           m_axil_arready;
    logic [DW-1:0]  m_axil_rdata;
    logic [1:0]     m_axil_rresp;
    logic           m_axil_rvalid;
    logic           m_axil_rready;
    logic [DLW-1:0] cfg_delay;
    logic [DW-1:0]  cfg_rdata_xor;
    logic           cfg_err_inject;
    logic [CW-1:0]  sts_outstanding;
    logic           sts_err_pending;

    always #5 clk = ~clk;

    axil_mitm_rd_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .DELAY_WIDTH(DLW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .cfg_delay(cfg_delay), .cfg_rdata_xor(cfg_rdata_xor),
        .cfg_err_inject(cfg_err_inject),
        .sts_outstanding(sts_outstanding), .sts_err_pending(sts_err_pending)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] xr;
        logic [7:0]  dly;
        logic        inj;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];
    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s_axil_araddr  = '0;
        s_axil_arprot  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        m_axil_arready = 1'b0;
        m_axil_rdata   = '0;
        m_axil_rresp   = '0;
        m_axil_rvalid  = 1'b0;
        cfg_delay      = '0;
        cfg_rdata_xor  = '0;
        cfg_err_inject = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        check("rst_arready", s_axil_arready, 0);
        check("rst_s_rvalid", s_axil_rvalid, 0);
        check("rst_m_arvalid", m_axil_arvalid, 0);
        check("rst_m_rready", m_axil_rready, 0);
        check("rst_outstanding", sts_outstanding, 0);
        check("rst_err_pending", sts_err_pending, 0);
        rst = 1'b0;
        #1;
        check("post_rst_arready", s_axil_arready, 1);
        check("post_rst_m_rready", m_axil_rready, 1);
        step();
    endtask

    // One AR through the register slice; downstream accepts it immediately.
    task automatic ar_xfer(input logic [31:0] addr);
        int k;
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = addr;
        s_axil_arprot  = 3'b010;
        k = 0;
        while (!s_axil_arready && k < 200) begin
            step();
            k++;
        end
        check("ar_accept_timeout", k < 200, 1);
        step();
        s_axil_arvalid = 1'b0;
        check("ar_m_arvalid", m_axil_arvalid, 1);
        check("ar_m_araddr", m_axil_araddr, addr);
        m_axil_arready = 1'b1;
        step();
        m_axil_arready = 1'b0;
    endtask

    // One response through the R path. Latency counts cycles from the
    // downstream R handshake to the first cycle s_axil_rvalid is seen.
    task automatic resp_xfer(input logic [31:0] d, input logic [1:0] r,
                             input logic [7:0] dly, input logic [31:0] xr,
                             input logic inj,
                             output logic [31:0] od, output logic [1:0] orr,
                             output int lat);
        int k;
        cfg_delay      = dly;
        cfg_rdata_xor  = xr;
        cfg_err_inject = inj;
        m_axil_rvalid  = 1'b1;
        m_axil_rdata   = d;
        m_axil_rresp   = r;
        k = 0;
        while (!m_axil_rready && k < 200) begin
            step();
            k++;
        end
        check("r_capture_timeout", k < 200, 1);
        step();
        m_axil_rvalid  = 1'b0;
        cfg_err_inject = 1'b0;
        // Reprogram after capture; the in-flight response must not change.
        cfg_delay      = DLW'($urandom);
        cfg_rdata_xor  = $urandom;
        lat = 1;
        while (!s_axil_rvalid && lat < 400) begin
            step();
            lat++;
        end
        od  = s_axil_rdata;
        orr = s_axil_rresp;
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;
        cfg_delay     = '0;
        cfg_rdata_xor = '0;
    endtask

    initial begin
        logic [31:0] od;
        logic [1:0]  orr;
        int          lat;
        int          n;
        int          seen;
        bit          ok;
        bit          hs;

        vecs[0] = '{32'h0000_1000, 32'h1234_5678, 2'b00, 32'h0000_0000, 8'd5,   1'b0, 32'h1234_5678, 2'b00, 6};
        vecs[1] = '{32'h0000_2004, 32'hA5A5_A5A5, 2'b00, 32'h0000_00FF, 8'd0,   1'b0, 32'hA5A5_A55A, 2'b00, 1};
        vecs[2] = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 2'b11, 32'hFFFF_FFFF, 8'd1,   1'b0, 32'h2152_4110, 2'b11, 2};
        vecs[3] = '{32'h0000_0000, 32'h0000_0001, 2'b00, 32'h0000_0000, 8'd255, 1'b1, 32'h0000_0001, 2'b10, 256};
        vecs[4] = '{32'h0000_0030, 32'h0F0F_0F0F, 2'b01, 32'hF0F0_F0F0, 8'd2,   1'b0, 32'hFFFF_FFFF, 2'b01, 3};

        do_reset();

        // Single-read vectors
        for (int i = 0; i < 5; i++) begin
            ar_xfer(vecs[i].addr);
            check($sformatf("vec%0d_outstanding_1", i), sts_outstanding, 1);
            resp_xfer(vecs[i].data, vecs[i].resp, vecs[i].dly, vecs[i].xr, vecs[i].inj, od, orr, lat);
            check($sformatf("vec%0d_rdata", i), od, vecs[i].exp_data);
            check($sformatf("vec%0d_rresp", i), orr, vecs[i].exp_resp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_outstanding_0", i), sts_outstanding, 0);
        end

        // Four back-to-back ARs fill the outstanding budget
        s_axil_arvalid = 1'b1;
        s_axil_arprot  = 3'b001;
        m_axil_arready = 1'b1;
        n = 0;
        seen = 0;
        ok = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (m_axil_arvalid) begin
                if (m_axil_araddr !== 32'(32'h100 + seen * 4)) ok = 1'b0;
                seen++;
            end
            s_axil_araddr = 32'(32'h100 + n * 4);
            hs = s_axil_arready;
            step();
            if (hs) n++;
        end
        s_axil_arvalid = 1'b0;
        if (m_axil_arvalid) begin
            if (m_axil_araddr !== 32'(32'h100 + seen * 4)) ok = 1'b0;
            seen++;
        end
        step();
        m_axil_arready = 1'b0;
        check("b2b_ar_addr_order", ok, 1);
        check("b2b_ar_forwarded", seen, 4);
        check("b2b_outstanding_full", sts_outstanding, 4);
        ok = 1'b1;
        s_axil_arvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (s_axil_arready !== 1'b0) ok = 1'b0;
            step();
        end
        s_axil_arvalid = 1'b0;
        check("b2b_arready_low_when_full", ok, 1);
        check("b2b_outstanding_held", sts_outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            resp_xfer(32'(32'hB000 + i), 2'b00, 8'd0, 32'h0, 1'b0, od, orr, lat);
            check($sformatf("b2b_r%0d_data", i), od, 32'(32'hB000 + i));
            if (i == 0) begin
                check("b2b_arready_after_first_r", s_axil_arready, 1);
                check("b2b_outstanding_after_first_r", sts_outstanding, 3);
            end
        end
        check("b2b_outstanding_drained", sts_outstanding, 0);

        // Error injection: two pulses arm once, only the next response gets SLVERR
        cfg_err_inject = 1'b1;
        step();
        cfg_err_inject = 1'b0;
        check("inj_pending_set", sts_err_pending, 1);
        step();
        cfg_err_inject = 1'b1;
        step();
        cfg_err_inject = 1'b0;
        check("inj_pending_still_set", sts_err_pending, 1);
        resp_xfer(32'h1111_1111, 2'b00, 8'd0, 32'h0, 1'b0, od, orr, lat);
        check("inj_first_resp", orr, 2'b10);
        check("inj_first_data", od, 32'h1111_1111);
        check("inj_pending_cleared", sts_err_pending, 0);
        resp_xfer(32'h2222_2222, 2'b00, 8'd0, 32'h0, 1'b0, od, orr, lat);
        check("inj_second_resp", orr, 2'b00);
        check("unsolicited_outstanding_sat0", sts_outstanding, 0);

        // Upstream stalls in R_OUT with a new downstream response waiting
        cfg_delay     = '0;
        cfg_rdata_xor = '0;
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'hCAFE_F00D;
        m_axil_rresp  = 2'b00;
        step();
        m_axil_rdata  = 32'h0BAD_C0DE;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_axil_rready !== 1'b0 || s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'hCAFE_F00D) ok = 1'b0;
            step();
        end
        check("stall_hold", ok, 1);
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;
        check("stall_m_rready_back", m_axil_rready, 1);
        step();
        m_axil_rvalid = 1'b0;
        check("stall_second_rvalid", s_axil_rvalid, 1);
        check("stall_second_rdata", s_axil_rdata, 32'h0BAD_C0DE);
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;

        // Reset in the middle of a held response
        ar_xfer(32'h0000_0400);
        ar_xfer(32'h0000_0404);
        check("midrst_outstanding_2", sts_outstanding, 2);
        cfg_delay     = 8'd10;
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'h5555_AAAA;
        step();
        m_axil_rvalid = 1'b0;
        step();
        step();
        check("midrst_in_delay", s_axil_rvalid, 0);
        rst = 1'b1;
        step();
        check("midrst_rvalid", s_axil_rvalid, 0);
        check("midrst_outstanding", sts_outstanding, 0);
        check("midrst_m_arvalid", m_axil_arvalid, 0);
        check("midrst_arready", s_axil_arready, 0);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("midrst_release_arready", s_axil_arready, 1);
        check("midrst_release_m_rready", m_axil_rready, 1);
        step();
        ar_xfer(vecs[1].addr);
        resp_xfer(vecs[1].data, vecs[1].resp, vecs[1].dly, vecs[1].xr, vecs[1].inj, od, orr, lat);
        check("midrst_fresh_rdata", od, vecs[1].exp_data);
        check("midrst_fresh_latency", lat, vecs[1].exp_lat);
        check("midrst_fresh_outstanding", sts_outstanding, 0);

        // Randomized traffic against a transaction-level model:
        // one response slot, an ordered timeline, a bounded counter.
        do_reset();
        begin
            int          mo_cnt;
            bit          mo_arp;
            logic [31:0] mo_ara;
            logic [2:0]  mo_arpr;
            bit          mo_arm;
            bit          mo_have;
            logic [31:0] mo_dat;
            logic [1:0]  mo_code;
            longint      mo_rdy;
            longint      cyc;
            bit          e_arready, e_srv;
            bit          h_ar, h_mr, h_sr;

            mo_cnt = 0; mo_arp = 0; mo_ara = '0; mo_arpr = '0; mo_arm = 0;
            mo_have = 0; mo_dat = '0; mo_code = '0; mo_rdy = 0; cyc = 0;
            for (int i = 0; i < 3000; i++) begin
                e_arready = !mo_arp && (mo_cnt < MO);
                e_srv     = mo_have && (cyc >= mo_rdy);
                check("rnd_arready", s_axil_arready, e_arready);
                check("rnd_m_arvalid", m_axil_arvalid, mo_arp);
                if (mo_arp) begin
                    check("rnd_m_araddr", m_axil_araddr, mo_ara);
                    check("rnd_m_arprot", m_axil_arprot, mo_arpr);
                end
                check("rnd_m_rready", m_axil_rready, !mo_have);
                check("rnd_s_rvalid", s_axil_rvalid, e_srv);
                if (e_srv) begin
                    check("rnd_s_rdata", s_axil_rdata, mo_dat);
                    check("rnd_s_rresp", s_axil_rresp, mo_code);
                end
                check("rnd_outstanding", sts_outstanding, mo_cnt);
                check("rnd_err_pending", sts_err_pending, mo_arm);

                s_axil_arvalid = ($urandom % 3) != 0;
                s_axil_araddr  = $urandom;
                s_axil_arprot  = 3'($urandom);
                m_axil_arready = 1'($urandom);
                m_axil_rvalid  = ($urandom % 3) == 0;
                m_axil_rdata   = $urandom;
                m_axil_rresp   = 2'($urandom);
                s_axil_rready  = ($urandom % 3) != 0;
                cfg_delay      = DLW'($urandom % 4);
                cfg_rdata_xor  = $urandom;
                cfg_err_inject = ($urandom % 16) == 0;

                h_ar = s_axil_arvalid && e_arready;
                h_mr = m_axil_rvalid && !mo_have;
                h_sr = e_srv && s_axil_rready;

                if (h_ar) begin
                    mo_arp  = 1;
                    mo_ara  = s_axil_araddr;
                    mo_arpr = s_axil_arprot;
                end else if (mo_arp && m_axil_arready) begin
                    mo_arp = 0;
                end
                if (h_ar && !h_sr && mo_cnt < MO) mo_cnt++;
                else if (h_sr && !h_ar && mo_cnt > 0) mo_cnt--;

                if (h_mr) begin
                    mo_have = 1;
                    mo_dat  = m_axil_rdata ^ cfg_rdata_xor;
                    mo_code = (mo_arm || cfg_err_inject) ? 2'b10 : m_axil_rresp;
                    mo_arm  = 0;
                    mo_rdy  = cyc + 1 + longint'(cfg_delay);
                end else if (cfg_err_inject) begin
                    mo_arm = 1;
                end
                if (h_sr) mo_have = 0;

                step();
                cyc++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
